seven_segment_scan: RTL and testbench
=====================================

// Module: seven_segment_scan
// PURPOSE
//  Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
//  Latches a packed BCD/hex value on a load strobe and scans one digit per refresh tick.
//  Adds hex glyphs, per-digit decimal points, leading-zero suppression and blanking.
//  Sits between the controller's status/speed registers and the board display pins.
// PARAMETERS
//  DIGITS    4      number of digits scanned, legal 1..8
//  CLK_DIV   50000  clk cycles per digit slot, legal >= 2
//  HEX_MODE  0      0: codes 10..15 show dash 7'h3F; 1: show A,b,C,d,E,F
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  value        in   4*DIGITS   packed nibbles, digit 0 = value[3:0] (rightmost)
//  dp           in   DIGITS     decimal-point request per digit, 1 = lit
//  load         in   1          1-cycle strobe: capture value/dp into shadow regs
//  blank        in   1          1 = all digits dark
//  lz_suppress  in   1          1 = blank leading zero digits
//  seg_n        out  7          segments {g,f,e,d,c,b,a}, active-low
//  dp_n         out  1          decimal point, active-low
//  an_n         out  DIGITS     digit enables, active-low, one-hot-low while lit
//  frame_start  out  1          1-cycle pulse when digit 0 is driven
// BEHAVIOUR
//  Reset: prescaler=0, idx=DIGITS-1, shadow value/dp=0, seg_n=7'h7F, dp_n=1,
//   an_n=all ones, frame_start=0. Reset mid-scan returns to this state at once.
//  Prescaler counts 0..CLK_DIV-1; tick = (count==CLK_DIV-1); count wraps to 0.
//  On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1; seg_n/dp_n/an_n registered for
//   the new idx at the same edge; first tick after reset shows digit 0.
//  Outputs hold between ticks; frame_start=1 only in the cycle after the tick
//   that moved idx to 0.
//  load=1: shadow <= value, dp; visible from next tick (no mid-slot glitch).
//   load on the tick edge: tick uses old shadow, new data from following tick.
//  Glyphs 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). Codes 10..15: HEX_MODE=1 ->
//   08,03,46,21,06,0E; HEX_MODE=0 -> 3F (dash).
//  Leading zero: digit i (i>0) is suppressed when lz_suppress=1 and nibbles
//   DIGITS-1..i of shadow are all 0. Digit 0 never suppressed. Suppressed slot:
//   an_n all ones, seg_n=7'h7F, dp_n=1; a lit dp does not un-suppress digit.
//  blank=1: an_n all ones, seg_n=7'h7F, dp_n=1 at next clk edge (not tick-gated);
//   prescaler, idx, frame_start keep running. blank 1->0: digits reappear
//   at next tick.
//  Lit slot: an_n bit idx = 0, others 1; dp_n = ~dp_shadow[idx].
//  Prescaler width = clog2(CLK_DIV); idx width = clog2(DIGITS), min 1.
//  DIGITS=1: idx stays 0, frame_start pulses every tick.
// TESTING (DIGITS=4, CLK_DIV=4 unless noted)
//  Reset, load value=16'h1234, dp=0 -> an_n cycles 1110,1101,1011,0111 each
//   4 clks; seg_n 19,30,24,79 (digit0..3); frame_start once per 16 clks.
//  value=16'h00A7, HEX_MODE=1, lz_suppress=1 -> digit0 78, digit1 08, digits2,3
//   an_n=1111; HEX_MODE=0 -> digit1 shows 3F.
//  value=16'h0000, lz_suppress=1, dp=4'b0100 -> only digit0 lit with 7'h40;
//   digit2 dark, dp_n stays 1 throughout.
//  blank asserted mid-slot -> next clk an_n=1111, seg_n=7F; release -> lit
//   again from next tick with correct digit order unchanged.
//  load 16'h5678 mid-slot of digit1 -> digit1 keeps old glyph until tick,
//   next slot (digit2) shows 02 from new shadow.
//  Assert rst_n low mid-slot -> outputs immediately 7F/1/1111, idx=3;
//   after release first tick drives digit0.

Source files
------------

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexed common-anode 7-segment driver with hex glyphs,
// per-digit decimal points, leading-zero suppression and blanking.
module seven_segment_scan #(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 50000,
    parameter int HEX_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank,
    input  logic                  lz_suppress,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_start
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       cnt;
    logic [IW-1:0]       idx, nidx;
    logic [4*DIGITS-1:0] sval;
    logic [DIGITS-1:0]   sdp;
    logic [DIGITS:0]     lz;
    logic [3:0]          nib;
    logic                tick, sup;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = HEX_MODE != 0 ? 7'h08 : 7'h3F;
            4'hB: glyph = HEX_MODE != 0 ? 7'h03 : 7'h3F;
            4'hC: glyph = HEX_MODE != 0 ? 7'h46 : 7'h3F;
            4'hD: glyph = HEX_MODE != 0 ? 7'h21 : 7'h3F;
            4'hE: glyph = HEX_MODE != 0 ? 7'h06 : 7'h3F;
            default: glyph = HEX_MODE != 0 ? 7'h0E : 7'h3F;
        endcase
    endfunction

    // lz[i] = nibbles DIGITS-1..i of the shadow are all zero
    always_comb begin
        lz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--)
            lz[i] = lz[i+1] && (sval[4*i +: 4] == 4'h0);
    end

    assign tick = cnt == PW'(CLK_DIV - 1);
    assign nidx = idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
    assign nib  = sval[{nidx, 2'b00} +: 4];
    assign sup  = lz_suppress && nidx != '0 && lz[nidx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= IW'(DIGITS - 1);
            sval        <= '0;
            sdp         <= '0;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + PW'(1);
            frame_start <= tick && nidx == '0;
            if (load) begin
                sval <= value;
                sdp  <= dp;
            end
            if (tick)
                idx <= nidx;
            // blank acts on every edge; lit digits only ever change on a tick
            if (blank || (tick && sup)) begin
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
                an_n  <= '1;
            end else if (tick) begin
                seg_n <= glyph(nib);
                dp_n  <= ~sdp[nidx];
                an_n  <= ~(DIGITS'(1) << nidx);
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: directed scoreboard bench, DIGITS=4, CLK_DIV=4, with a
// HEX_MODE=1 and a HEX_MODE=0 instance sharing the same stimulus.
module tb_seven_segment_scan;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load, blank, lz_suppress;
    logic [6:0]  seg1, seg0;
    logic        dp1, dp0, fs1, fs0;
    logic [3:0]  an1, an0;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] w;
        logic [3:0] an;
        logic [6:0] s1;
        logic [6:0] s0;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t  q[$];
    string tq[$];

    always #5 clk = ~clk;

    seven_segment_scan #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1)) u_hex (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
        .blank(blank), .lz_suppress(lz_suppress), .seg_n(seg1), .dp_n(dp1),
        .an_n(an1), .frame_start(fs1)
    );

    seven_segment_scan #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(0)) u_dash (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .load(load),
        .blank(blank), .lz_suppress(lz_suppress), .seg_n(seg0), .dp_n(dp0),
        .an_n(an0), .frame_start(fs0)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // w = clock edges to wait before the expected state is sampled
    task automatic push(input string tag, input int w, input logic [3:0] an,
                        input logic [6:0] s1, input logic [6:0] s0,
                        input logic d, input logic fs);
        exp_t e;
        e = '{w: 4'(w), an: an, s1: s1, s0: s0, dp: d, fs: fs};
        q.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic dark(input string tag, input int w, input logic fs);
        push(tag, w, 4'hF, 7'h7F, 7'h7F, 1'b1, fs);
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (q.size() > 0) begin
            e = q.pop_front();
            t = tq.pop_front();
            wait_cyc(int'(e.w));
            cmp({t, " an_n hex"},  {4'h0, an1}, {4'h0, e.an});
            cmp({t, " an_n dash"}, {4'h0, an0}, {4'h0, e.an});
            cmp({t, " seg_n hex"},  {1'b0, seg1}, {1'b0, e.s1});
            cmp({t, " seg_n dash"}, {1'b0, seg0}, {1'b0, e.s0});
            cmp({t, " dp_n hex"},  {7'h0, dp1}, {7'h0, e.dp});
            cmp({t, " dp_n dash"}, {7'h0, dp0}, {7'h0, e.dp});
            cmp({t, " frame_start hex"},  {7'h0, fs1}, {7'h0, e.fs});
            cmp({t, " frame_start dash"}, {7'h0, fs0}, {7'h0, e.fs});
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        wait_cyc(1);
        load  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; value = '0; dp = '0; load = 1'b0; blank = 1'b0; lz_suppress = 1'b0;
        dark("reset", 2, 1'b0);
        drain();
        // basic scan of 1234
        rst_n = 1'b1;
        do_load(16'h1234, 4'h0);
        push("d0_1234", 3, 4'hE, 7'h19, 7'h19, 1'b1, 1'b1);
        push("hold_1234", 1, 4'hE, 7'h19, 7'h19, 1'b1, 1'b0);
        push("d1_1234", 3, 4'hD, 7'h30, 7'h30, 1'b1, 1'b0);
        push("d2_1234", 4, 4'hB, 7'h24, 7'h24, 1'b1, 1'b0);
        push("d3_1234", 4, 4'h7, 7'h79, 7'h79, 1'b1, 1'b0);
        push("d0_1234b", 4, 4'hE, 7'h19, 7'h19, 1'b1, 1'b1);
        drain();
        // hex digit plus leading-zero suppression
        lz_suppress = 1'b1;
        do_load(16'h00A7, 4'h0);
        push("d1_A", 3, 4'hD, 7'h08, 7'h3F, 1'b1, 1'b0);
        dark("d2_lz", 4, 1'b0);
        dark("d3_lz", 4, 1'b0);
        push("d0_7", 4, 4'hE, 7'h78, 7'h78, 1'b1, 1'b1);
        drain();
        // all zero: only digit 0 lit, dp on a suppressed digit stays dark
        do_load(16'h0000, 4'b0100);
        dark("d1_zero", 3, 1'b0);
        dark("d2_zero_dp", 4, 1'b0);
        dark("d3_zero", 4, 1'b0);
        push("d0_zero", 4, 4'hE, 7'h40, 7'h40, 1'b1, 1'b1);
        drain();
        // remaining hex glyphs
        lz_suppress = 1'b0;
        do_load(16'h8CEF, 4'h0);
        push("d1_E", 3, 4'hD, 7'h06, 7'h3F, 1'b1, 1'b0);
        push("d2_C", 4, 4'hB, 7'h46, 7'h3F, 1'b1, 1'b0);
        push("d3_8", 4, 4'h7, 7'h00, 7'h00, 1'b1, 1'b0);
        push("d0_F", 4, 4'hE, 7'h0E, 7'h3F, 1'b1, 1'b1);
        drain();
        // decimal point on digit 0, then blanking across a full frame
        do_load(16'h1234, 4'b0001);
        push("d1_dp", 3, 4'hD, 7'h30, 7'h30, 1'b1, 1'b0);
        push("d2_dp", 4, 4'hB, 7'h24, 7'h24, 1'b1, 1'b0);
        push("d3_dp", 4, 4'h7, 7'h79, 7'h79, 1'b1, 1'b0);
        push("d0_dp", 4, 4'hE, 7'h19, 7'h19, 1'b0, 1'b1);
        drain();
        wait_cyc(1);
        blank = 1'b1;
        dark("blank_now", 1, 1'b0);
        dark("blank_d1", 2, 1'b0);
        dark("blank_d2", 4, 1'b0);
        dark("blank_d3", 4, 1'b0);
        dark("blank_d0", 4, 1'b1);
        drain();
        blank = 1'b0;
        dark("unblank_hold", 1, 1'b0);
        push("unblank_d1", 3, 4'hD, 7'h30, 7'h30, 1'b1, 1'b0);
        drain();
        // load mid-slot of digit 1
        wait_cyc(1);
        value = 16'h5678; dp = 4'h0; load = 1'b1;
        push("midload_d1", 1, 4'hD, 7'h30, 7'h30, 1'b1, 1'b0);
        drain();
        load = 1'b0;
        push("midload_d2", 2, 4'hB, 7'h02, 7'h02, 1'b1, 1'b0);
        drain();
        // load coinciding with the tick edge
        wait_cyc(3);
        value = 16'h9999; load = 1'b1;
        push("tickload_d3", 1, 4'h7, 7'h12, 7'h12, 1'b1, 1'b0);
        drain();
        load = 1'b0;
        push("tickload_d0", 4, 4'hE, 7'h10, 7'h10, 1'b1, 1'b1);
        drain();
        // asynchronous reset mid-slot
        wait_cyc(2);
        rst_n = 1'b0;
        dark("async_reset", 0, 1'b0);
        drain();
        wait_cyc(1);
        rst_n = 1'b1;
        dark("post_reset_hold", 3, 1'b0);
        push("post_reset_d0", 1, 4'hE, 7'h40, 7'h40, 1'b1, 1'b1);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
